idct8_stream: RTL and testbench
===============================

// Module: idct8_stream
// PURPOSE
// - Streaming 8-point 1-D inverse DCT; inverse of the forward DCT row array in the same pipeline.
// - Takes serial coefficient blocks X(0..7) in natural order and emits reconstructed samples y(0..7) serially.
// - Uses an even/odd MAC stage followed by an output butterfly; sustains 1 sample/clk with ping-pong input banks.
// - Two instances with a transpose buffer between them form the 2-D IDCT.
// PARAMETERS
// - DATA_WIDTH  10  signed width of in_data and out_data
// - COE_WIDTH   10  signed coefficient width; Q1.(COE_WIDTH-1)
// PORTS
// - clk       in   1           clock, rising edge
// - rst_n     in   1           asynchronous reset, active-low
// - in_data   in   DATA_WIDTH  signed coefficient X(k), k = position in block
// - in_valid  in   1           qualifies in_data; gaps allowed, no backpressure
// - out_data  out  DATA_WIDTH  signed reconstructed sample y(n), n = 0..7
// - out_valid out  1           qualifies out_data
// - out_last  out  1           high with y(7) of each block
// BEHAVIOUR
// - Reset: out_data=0, out_valid=0, out_last=0, sample counter=0, bank select=0, engine idle, accumulators=0.
// - Input: 3-bit counter advances only on in_valid; word k is written to bank[sel][k].
//   - On the 8th valid word (k=7), sel toggles and the engine is triggered on the filled bank.
//   - Counter wraps 7->0.
// - Math: y(n) = sum_k M[n][k]*X(k), with M[n][k] = 0.5*c(k)*cos((2n+1)k*pi/16).
//   - c(0)=1/sqrt2, c(k>0)=1.
//   - Stored coe = round(M*2^(COE_WIDTH-1)); for default widths the magnitudes are 181,251,237,213,181,142,98,50 for k=0..7.
// - Engine FSM: IDLE -> MAC0..MAC3 -> BFLY -> IDLE.
//   - IDLE: waits for trigger.
//   - MACm: reads X(2m) and X(2m+1) in 1 cycle and updates 4 even accumulators E[n] += coe*X(2m) and 4 odd accumulators O[n] += coe*X(2m+1), n = 0..3.
//   - MAC0 loads the accumulators instead of adding.
//   - BFLY: y(n)=E[n]+O[n], y(7-n)=E[n]-O[n].
//   - Each y is rounded once: (acc + 2^(COE_WIDTH-2)) >>> (COE_WIDTH-1), arithmetic.
//   - Result is then reduced to DATA_WIDTH (see CONFIGURATION) and all 8 words are loaded into the output shift buffer.
//   - Trigger arriving in a non-IDLE state cannot occur (blocks are at least 8 clk apart); no queueing is needed.
// - Accumulator width is DATA_WIDTH+COE_WIDTH+3; no intermediate truncation.
// - Output: after load, the buffer emits y(0)..y(7) on 8 consecutive cycles with out_valid=1, independent of in_valid gaps.
//   - out_last=1 on y(7); outside emission, out_valid=0, out_last=0 and out_data holds its last value.
// - Timing: X(7) accepted in cycle t; MAC cycles t+1..t+4; BFLY t+5; y(0) valid t+6; y(7) t+13.
//   - For a gap-free block starting at cycle 0, y(0) appears at cycle 13.
// - Back-to-back blocks give a gap-free output stream: block B's load happens exactly on the cycle after A's y(7).
// - Simultaneous write of the new bank and engine read of the old bank is legal; the banks never alias.
// - rst_n asserted mid-block or mid-emission discards all partial data.
//   - The first block after release starts at k=0; no stale sample is ever emitted.
// CONFIGURATION
// - IDCT_SATURATE_EN defined:
//   - The rounded result is clipped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
// - IDCT_SATURATE_EN undefined:
//   - The low DATA_WIDTH bits are kept (two's-complement wrap).
//   - Saves comparators; valid only when the upstream range is guaranteed.
// TESTING (default params)
// - DC block X={64,0,0,0,0,0,0,0} gap-free -> 8 words of 23; out_valid cycles 13..20; out_last only at cycle 20.
// - X1-only block X(1)=100, rest 0 -> y(0)=49, y(7)=-49; y(n)=-y(7-n) for all n.
// - All X=511 with IDCT_SATURATE_EN -> y(0)=511 (clipped); without the macro -> y(0)=326 (1350 wrapped).
// - Two back-to-back DC blocks (64, then -64) -> 16 consecutive valid words: 8x 23 then 8x -23; out_last at words 8 and 16.
// - DC block with in_valid low every other cycle -> same 8x 23 output; y(0) appears 6 cycles after X(7).
// - rst_n pulsed after 5 words of block A, then a full DC(64) block -> no output from A; exactly 8x 23 follow.

Source files
------------

// File: rtl/idct8_stream.sv
// Streaming 8-point 1-D inverse DCT: ping-pong input banks, 4-cycle even/odd MAC, butterfly, 8-word output shifter.
// Optional macro IDCT_SATURATE_EN clips results to the signed DATA_WIDTH range; otherwise the low bits are kept.
module idct8_stream #(
    parameter int DATA_WIDTH = 10,
    parameter int COE_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last
);

    localparam int AW = DATA_WIDTH + COE_WIDTH + 3;
    localparam int PW = DATA_WIDTH + COE_WIDTH;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MAC0 = 3'd1;
    localparam logic [2:0] ST_MAC1 = 3'd2;
    localparam logic [2:0] ST_MAC2 = 3'd3;
    localparam logic [2:0] ST_MAC3 = 3'd4;
    localparam logic [2:0] ST_BFLY = 3'd5;

    // Q1.9 basis rows n=0..3; index [n][m] pairs with X(2m) (even) and X(2m+1) (odd).
    localparam int COE_EVEN [4][4] = '{'{181,  237,  181,   98},
                                       '{181,   98, -181, -237},
                                       '{181,  -98, -181,  237},
                                       '{181, -237,  181,  -98}};
    localparam int COE_ODD  [4][4] = '{'{251,  213,  142,   50},
                                       '{213,  -50, -251, -142},
                                       '{142, -251,   50,  213},
                                       '{ 50, -142,  213, -251}};

    localparam logic signed [AW:0] RND =
        {{(AW - COE_WIDTH + 2){1'b0}}, 1'b1, {(COE_WIDTH - 2){1'b0}}};
`ifdef IDCT_SATURATE_EN
    localparam logic signed [AW:0] SAT_MAX =
        {{(AW - DATA_WIDTH + 2){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [AW:0] SAT_MIN =
        {{(AW - DATA_WIDTH + 2){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
`endif

    function automatic logic signed [COE_WIDTH-1:0] coe_of(input int v);
        return COE_WIDTH'(v);
    endfunction

    function automatic logic signed [AW-1:0] mac_step(
        input logic signed [AW-1:0]         acc,
        input logic                         load,
        input logic signed [DATA_WIDTH-1:0] x,
        input logic signed [COE_WIDTH-1:0]  c
    );
        logic signed [PW-1:0] p;
        p = x * c;
        return load ? AW'(p) : acc + AW'(p);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] round_reduce(input logic signed [AW:0] s);
        logic signed [AW:0] r;
        r = (s + RND) >>> (COE_WIDTH - 1);
`ifdef IDCT_SATURATE_EN
        if (r > SAT_MAX) return SAT_MAX[DATA_WIDTH-1:0];
        if (r < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
`endif
        return r[DATA_WIDTH-1:0];
    endfunction

    logic [2:0]                   state_q, state_d;
    logic [2:0]                   cnt_q, cnt_d;
    logic                         sel_q, sel_d;
    logic                         rd_sel_q, rd_sel_d;
    logic                         trig;
    logic [DATA_WIDTH-1:0]        bank_q [2][8];
    logic [DATA_WIDTH-1:0]        bank_d [2][8];
    logic signed [AW-1:0]         acc_e_q [4];
    logic signed [AW-1:0]         acc_e_d [4];
    logic signed [AW-1:0]         acc_o_q [4];
    logic signed [AW-1:0]         acc_o_d [4];
    logic [1:0]                   mac_m;
    logic signed [DATA_WIDTH-1:0] x_e, x_o;
    logic [DATA_WIDTH-1:0]        y_v [8];
    logic [DATA_WIDTH-1:0]        obuf_q [7];
    logic [DATA_WIDTH-1:0]        obuf_d [7];
    logic [2:0]                   orem_q, orem_d;
    logic [DATA_WIDTH-1:0]        out_data_q, out_data_d;
    logic                         out_valid_q, out_valid_d;
    logic                         out_last_q, out_last_d;

    // Input side: the write bank flips after X(7); the engine reads the other bank.
    always_comb begin
        bank_d = bank_q;
        cnt_d  = cnt_q;
        sel_d  = sel_q;
        trig   = 1'b0;
        if (in_valid) begin
            bank_d[sel_q][cnt_q] = in_data;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                sel_d = ~sel_q;
                trig  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_sel_d = rd_sel_q;
        acc_e_d  = acc_e_q;
        acc_o_d  = acc_o_q;
        mac_m    = state_q[1:0] - 2'd1;
        x_e      = bank_q[rd_sel_q][{mac_m, 1'b0}];
        x_o      = bank_q[rd_sel_q][{mac_m, 1'b1}];
        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    state_d  = ST_MAC0;
                    rd_sel_d = sel_q;
                end
            end
            ST_MAC0, ST_MAC1, ST_MAC2, ST_MAC3: begin
                for (int n = 0; n < 4; n++) begin
                    acc_e_d[n] = mac_step(acc_e_q[n], state_q == ST_MAC0, x_e,
                                          coe_of(COE_EVEN[n][mac_m]));
                    acc_o_d[n] = mac_step(acc_o_q[n], state_q == ST_MAC0, x_o,
                                          coe_of(COE_ODD[n][mac_m]));
                end
                state_d = state_q + 3'd1;
            end
            ST_BFLY: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Butterfly: rows 7-n reuse E[n] with the odd part negated.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            y_v[n]     = round_reduce({acc_e_q[n][AW-1], acc_e_q[n]} + {acc_o_q[n][AW-1], acc_o_q[n]});
            y_v[7 - n] = round_reduce({acc_e_q[n][AW-1], acc_e_q[n]} - {acc_o_q[n][AW-1], acc_o_q[n]});
        end
    end

    // A new load always lands the cycle after the previous y(7), so it never cuts emission short.
    always_comb begin
        obuf_d      = obuf_q;
        orem_d      = orem_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        if (state_q == ST_BFLY) begin
            out_data_d  = y_v[0];
            for (int i = 0; i < 7; i++) obuf_d[i] = y_v[i + 1];
            orem_d      = 3'd7;
            out_valid_d = 1'b1;
        end else if (orem_q != 3'd0) begin
            out_data_d  = obuf_q[0];
            for (int i = 0; i < 6; i++) obuf_d[i] = obuf_q[i + 1];
            orem_d      = orem_q - 3'd1;
            out_valid_d = 1'b1;
            out_last_d  = (orem_q == 3'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sel_q       <= 1'b0;
            rd_sel_q    <= 1'b0;
            orem_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < 8; i++) bank_q[b][i] <= '0;
            for (int n = 0; n < 4; n++) begin
                acc_e_q[n] <= '0;
                acc_o_q[n] <= '0;
            end
            for (int i = 0; i < 7; i++) obuf_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            rd_sel_q    <= rd_sel_d;
            orem_q      <= orem_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            bank_q      <= bank_d;
            acc_e_q     <= acc_e_d;
            acc_o_q     <= acc_o_d;
            obuf_q      <= obuf_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_idct8_stream.sv
// Bench for idct8_stream: a cosine-based IDCT model predicts every output word and the cycle it must appear on.
module tb_idct8_stream;

    localparam int DW = 10;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;

    idct8_stream #(.DATA_WIDTH(DW), .COE_WIDTH(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int fails   = 0;

    // ---------------- model ----------------
    int            blk [8];
    int            stim [8];
    int            word_idx = 0;
    int            x7_cyc = 0;
    logic [DW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    bit            exp_last_q[$];

    function automatic int coe_m(int n, int k);
        real a, v;
        a = real'((2 * n + 1) * k) * 3.14159265358979 / 16.0;
        v = 0.5 * $cos(a) * real'(1 << (CW - 1));
        if (k == 0) v = v / $sqrt(2.0);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    function automatic int model_y(int n);
        longint acc, r, half;
        acc = 0;
        for (int k = 0; k < 8; k++) acc += longint'(coe_m(n, k)) * longint'(blk[k]);
        r = (acc + (longint'(1) << (CW - 2))) >>> (CW - 1);
        half = longint'(1) << (DW - 1);
`ifdef IDCT_SATURATE_EN
        if (r > half - 1) r = half - 1;
        if (r < -half) r = -half;
`else
        r = r & ((half << 1) - 1);
        if (r >= half) r = r - (half << 1);
`endif
        return int'(r);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- compare process ----------------
    bit            mon_en = 1'b0;
    bit            exp_hit;
    logic [DW-1:0] hold_val = '0;
    int            log_d[$];
    int            log_c[$];
    bit            log_l[$];

    always @(negedge clk) begin
        if (mon_en) begin
            exp_hit = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
            vectors++;
            if (out_valid !== exp_hit) begin
                fails++;
                $display("FAIL out_valid @%0d: got %b, expected %b", cyc, out_valid, exp_hit);
            end
            if (exp_hit) begin
                vectors++;
                if (out_data !== exp_q[0]) begin
                    fails++;
                    $display("FAIL out_data @%0d: got %0d, expected %0d", cyc,
                             $signed(out_data), $signed(exp_q[0]));
                end
                vectors++;
                if (out_last !== exp_last_q[0]) begin
                    fails++;
                    $display("FAIL out_last @%0d: got %b, expected %b", cyc, out_last, exp_last_q[0]);
                end
                void'(exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
                void'(exp_last_q.pop_front());
            end else begin
                vectors++;
                if (out_last !== 1'b0 || out_data !== hold_val) begin
                    fails++;
                    $display("FAIL idle_hold @%0d: got data %0d last %b, expected data %0d last 0",
                             cyc, $signed(out_data), out_last, $signed(hold_val));
                end
            end
            hold_val = out_data;
            if (out_valid === 1'b1) begin
                log_d.push_back(int'($signed(out_data)));
                log_c.push_back(cyc);
                log_l.push_back(out_last);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_word(input bit v, input int x);
        int yv;
        @(negedge clk);
        in_valid = v;
        in_data  = x[DW-1:0];
        if (v) begin
            blk[word_idx] = x;
            if (word_idx == 7) begin
                x7_cyc = cyc;
                for (int n = 0; n < 8; n++) begin
                    yv = model_y(n);
                    exp_q.push_back(yv[DW-1:0]);
                    exp_cyc_q.push_back(cyc + 6 + n);
                    exp_last_q.push_back(n == 7);
                end
            end
            word_idx = (word_idx + 1) % 8;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_word(1'b0, 0);
    endtask

    // mode 0: gap-free, 1: gap between every word, 2: random gaps
    task automatic send_block(input int mode);
        for (int k = 0; k < 8; k++) begin
            if (mode == 1 && k > 0) send_word(1'b0, 0);
            if (mode == 2) while ($urandom_range(0, 3) == 0) send_word(1'b0, 0);
            send_word(1'b1, stim[k]);
        end
    endtask

    task automatic set_dc(input int v);
        stim[0] = v;
        for (int k = 1; k < 8; k++) stim[k] = 0;
    endtask

    task automatic clear_log();
        @(negedge clk);
        #1;
        log_d.delete();
        log_c.delete();
        log_l.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        word_idx = 0;
        exp_q.delete();
        exp_cyc_q.delete();
        exp_last_q.delete();
        hold_val = '0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    int c0, nlast, n_before, wait_cnt;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;

        // pin the model against hand-computed values
        for (int k = 0; k < 8; k++) blk[k] = 0;
        blk[0] = 64;
        chk("model_dc_y0", model_y(0), 23);
        chk("model_dc_y5", model_y(5), 23);
        blk[0] = 0; blk[1] = 100;
        chk("model_x1_y0", model_y(0), 49);
        chk("model_x1_y7", model_y(7), -49);
        for (int k = 0; k < 8; k++) blk[k] = 511;
`ifdef IDCT_SATURATE_EN
        chk("model_max_y0", model_y(0), 511);
`else
        chk("model_max_y0", model_y(0), 326);
`endif

        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_last", int'(out_last), 0);
        mon_en = 1'b1;

        // DC block, gap-free
        clear_log();
        set_dc(64);
        send_word(1'b0, 0);
        c0 = cyc + 1;
        send_block(0);
        idle(20);
        chk("dc_count", log_d.size(), 8);
        if (log_d.size() == 8) begin
            nlast = 0;
            for (int i = 0; i < 8; i++) begin
                chk("dc_value", log_d[i], 23);
                nlast += int'(log_l[i]);
            end
            chk("dc_first_cycle", log_c[0] - c0, 13);
            chk("dc_last_cycle", log_c[7] - c0, 20);
            chk("dc_last_count", nlast, 1);
            chk("dc_last_pos", int'(log_l[7]), 1);
        end

        // X(1)-only block
        clear_log();
        set_dc(0);
        stim[1] = 100;
        send_block(0);
        idle(20);
        chk("x1_count", log_d.size(), 8);
        if (log_d.size() == 8) begin
            chk("x1_y0", log_d[0], 49);
            chk("x1_y7", log_d[7], -49);
            for (int n = 0; n < 4; n++) chk("x1_antisym", log_d[n], -log_d[7 - n]);
        end

        // full-scale block
        clear_log();
        for (int k = 0; k < 8; k++) stim[k] = 511;
        send_block(0);
        idle(20);
        if (log_d.size() > 0) begin
`ifdef IDCT_SATURATE_EN
            chk("max_y0", log_d[0], 511);
`else
            chk("max_y0", log_d[0], 326);
`endif
        end else chk("max_count", 0, 8);

        // back-to-back DC blocks
        clear_log();
        set_dc(64);
        send_block(0);
        set_dc(-64);
        send_block(0);
        idle(20);
        chk("b2b_count", log_d.size(), 16);
        if (log_d.size() == 16) begin
            chk("b2b_span", log_c[15] - log_c[0], 15);
            chk("b2b_w8", log_d[7], 23);
            chk("b2b_w9", log_d[8], -23);
            chk("b2b_last8", int'(log_l[7]), 1);
            chk("b2b_last16", int'(log_l[15]), 1);
        end

        // DC block with in_valid low every other cycle
        clear_log();
        set_dc(64);
        send_block(1);
        idle(20);
        chk("gap_count", log_d.size(), 8);
        if (log_d.size() == 8) begin
            chk("gap_latency", log_c[0] - x7_cyc, 6);
            chk("gap_y3", log_d[3], 23);
        end

        // reset after 5 words of block A, then a DC block
        clear_log();
        for (int k = 0; k < 5; k++) send_word(1'b1, 64 + k);
        do_reset();
        set_dc(64);
        send_block(0);
        idle(20);
        chk("rstblk_count", log_d.size(), 8);
        if (log_d.size() == 8) for (int i = 0; i < 8; i++) chk("rstblk_value", log_d[i], 23);

        // reset in the middle of emission
        clear_log();
        set_dc(-64);
        send_block(0);
        idle(9);
        do_reset();
        n_before = log_d.size();
        idle(15);
        chk("rst_emit_quiet", log_d.size(), n_before);

        // randomized blocks
        for (int b = 0; b < 40; b++) begin
            for (int k = 0; k < 8; k++) begin
                if (b % 4 == 0) stim[k] = int'($urandom_range(0, 1023)) - 512;
                else            stim[k] = int'($urandom_range(0, 160)) - 80;
            end
            send_block((b % 3 == 0) ? 0 : 2);
            idle(int'($urandom_range(0, 2)));
        end

        wait_cnt = 0;
        while (exp_cyc_q.size() > 0 && wait_cnt < 60) begin
            idle(1);
            wait_cnt++;
        end
        chk("drain_pending", exp_cyc_q.size(), 0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
